// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU matmul sequencer.
// Holds the FSM state type and the default sizing that RTL and bench both use.
package tpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WLOAD,
    S_RUN,
    S_DONE
  } seq_state_e;

  localparam int DEF_MATRIX_SIZE = 64;
  localparam int DEF_ADDRESSSIZE = 10;

  // Row latency: SRAM read, input skew, array traversal and output de-skew.
  function automatic int resultLatFor(input int matrixSize);
    return 3 * matrixSize;
  endfunction

  localparam int DEF_RESULT_LAT = resultLatFor(DEF_MATRIX_SIZE);

endpackage

// File: rtl/tpu_addr_gen.sv
// Loadable base + offset address counter: load captures the base,
// each enabled cycle advances by one, wrapping silently at 2^WIDTH.
module tpu_addr_gen #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_base,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_addr
);

  logic [WIDTH-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
    end else if (i_en) begin
      r_addr <= r_addr + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/tpu_matmul_sequencer.sv
// Start/busy/done run controller for one matrix-multiply pass (weight reload,
// N UB row reads, N result writes). Define TPU_SEQ_PERF_EN to add perf_cycles.
module tpu_matmul_sequencer
  import tpu_pkg::*;
#(
  parameter int MATRIX_SIZE  = DEF_MATRIX_SIZE,
  parameter int ADDRESSSIZE  = DEF_ADDRESSSIZE,
  parameter int WLOAD_CYCLES = MATRIX_SIZE,
  parameter int RESULT_LAT   = resultLatFor(MATRIX_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE:0]   cfg_num_rows,
  input  logic [ADDRESSSIZE-1:0] cfg_src_base,
  input  logic [ADDRESSSIZE-1:0] cfg_dst_base,
  output logic                   busy,
  output logic                   done,
  output logic                   fifo_rd_en,
  output logic                   we_rl,
  output logic                   ub_rd_en,
  output logic [ADDRESSSIZE-1:0] ub_rd_addr,
  output logic                   res_wr_en,
  output logic [ADDRESSSIZE-1:0] res_wr_addr
`ifdef TPU_SEQ_PERF_EN
  ,
  output logic [31:0]            perf_cycles
`endif
);

  localparam logic [31:0] LAT     = 32'(RESULT_LAT);
  localparam logic [31:0] WL_LAST = 32'(WLOAD_CYCLES - 1);

  seq_state_e           r_state, w_nextState;
  logic [31:0]          r_cnt, w_nextCnt;
  logic [ADDRESSSIZE:0] r_numRows;
  logic [31:0]          w_numRows32, w_lastT;
  logic                 w_accept;
  logic r_busy, r_done, r_fifoRdEn, r_weRl, r_ubRdEn, r_resWrEn;
  logic w_busyNext, w_doneNext, w_fifoNext, w_weNext, w_rdNext, w_wrNext;

  assign w_numRows32 = 32'(r_numRows);
  assign w_lastT     = LAT + w_numRows32 - 32'd1;

  // Outputs are decoded from the next state so every strobe leaves a flop.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = S_WLOAD;
          w_nextCnt   = '0;
        end
      end
      S_WLOAD: begin
        if (abort) begin
          w_nextState = S_IDLE;
        end else if (r_cnt == WL_LAST) begin
          w_nextState = S_RUN;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + 32'd1;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_nextState = S_IDLE;
        end else if (r_cnt == w_lastT) begin
          w_nextState = S_DONE;
        end else begin
          w_nextCnt = r_cnt + 32'd1;
        end
      end
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase

    w_busyNext = (w_nextState == S_WLOAD) || (w_nextState == S_RUN);
    w_doneNext = (w_nextState == S_DONE);
    w_weNext   = (w_nextState == S_WLOAD);
    w_fifoNext = (w_nextState == S_WLOAD) && (r_state == S_IDLE);
    w_rdNext   = (w_nextState == S_RUN) && (w_nextCnt < w_numRows32);
    w_wrNext   = (w_nextState == S_RUN) && (w_nextCnt >= LAT) && (w_nextCnt <= w_lastT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_numRows  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fifoRdEn <= 1'b0;
      r_weRl     <= 1'b0;
      r_ubRdEn   <= 1'b0;
      r_resWrEn  <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= w_nextCnt;
      if (w_accept) begin
        r_numRows <= cfg_num_rows;
      end
      r_busy     <= w_busyNext;
      r_done     <= w_doneNext;
      r_fifoRdEn <= w_fifoNext;
      r_weRl     <= w_weNext;
      r_ubRdEn   <= w_rdNext;
      r_resWrEn  <= w_wrNext;
    end
  end

  // Each address counter steps after every cycle its strobe was high.
  tpu_addr_gen #(.WIDTH(ADDRESSSIZE)) u_rdAddr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_base (cfg_src_base),
    .i_en   (r_ubRdEn),
    .o_addr (ub_rd_addr)
  );

  tpu_addr_gen #(.WIDTH(ADDRESSSIZE)) u_wrAddr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_base (cfg_dst_base),
    .i_en   (r_resWrEn),
    .o_addr (res_wr_addr)
  );

  assign busy       = r_busy;
  assign done       = r_done;
  assign fifo_rd_en = r_fifoRdEn;
  assign we_rl      = r_weRl;
  assign ub_rd_en   = r_ubRdEn;
  assign res_wr_en  = r_resWrEn;

`ifdef TPU_SEQ_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf <= '0;
    end else if (w_accept) begin
      r_perf <= '0;
    end else if (r_busy) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_tpu_matmul_sequencer.sv
// Directed bench for tpu_matmul_sequencer (MATRIX_SIZE=4, WLOAD=4, RESULT_LAT=12).
// Cycle c of a pass is the clock period opened by the c-th edge after the start edge.
module tb_tpu_matmul_sequencer;
  import tpu_pkg::*;

  localparam int TB_MATRIX_SIZE = 4;
  localparam int TB_ADDR        = DEF_ADDRESSSIZE;
  localparam int TB_WLOAD       = 4;
  localparam int TB_RESULT_LAT  = resultLatFor(TB_MATRIX_SIZE);
  localparam int WINDOW         = 45;

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic [TB_ADDR:0]  cfgNumRows;
  logic [TB_ADDR-1:0] cfgSrc, cfgDst;
  logic              busy, done, fifoRdEn, weRl, ubRdEn, resWrEn;
  logic [TB_ADDR-1:0] ubRdAddr, resWrAddr;
`ifdef TPU_SEQ_PERF_EN
  logic [31:0]       perfCycles;
`endif

  always #5 clk = ~clk;

  tpu_matmul_sequencer #(
    .MATRIX_SIZE  (TB_MATRIX_SIZE),
    .ADDRESSSIZE  (TB_ADDR),
    .WLOAD_CYCLES (TB_WLOAD),
    .RESULT_LAT   (TB_RESULT_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .cfg_num_rows (cfgNumRows),
    .cfg_src_base (cfgSrc),
    .cfg_dst_base (cfgDst),
    .busy         (busy),
    .done         (done),
    .fifo_rd_en   (fifoRdEn),
    .we_rl        (weRl),
    .ub_rd_en     (ubRdEn),
    .ub_rd_addr   (ubRdAddr),
    .res_wr_en    (resWrEn),
    .res_wr_addr  (resWrAddr)
`ifdef TPU_SEQ_PERF_EN
    ,
    .perf_cycles  (perfCycles)
`endif
  );

  int checkCount = 0;
  int passCount  = 0;

  // Per-cycle trace of one pass, filled by applyStimulus.
  logic trBusy [0:WINDOW];
  logic trDone [0:WINDOW];
  logic trWe   [0:WINDOW];
  logic trFifo [0:WINDOW];
  logic trRd   [0:WINDOW];
  logic trWr   [0:WINDOW];
  logic [TB_ADDR-1:0] trRdAddr [0:WINDOW];
  logic [TB_ADDR-1:0] trWrAddr [0:WINDOW];

  int nRd, nWr, nDone, doneCyc, firstRd, firstWr, nOverlap, nBusy, nWe, nFifo;
  int weShapeErr, fifoShapeErr, rdAddrErr, wrAddrErr;
  logic [TB_ADDR-1:0] lastRdAddr, lastWrAddr;

  typedef struct {
    int                 n;
    logic [TB_ADDR-1:0] src;
    logic [TB_ADDR-1:0] dst;
    int                 expDone;
    int                 expBusy;
    int                 expOverlap;
    int                 expFirstRd;
    int                 expFirstWr;
    logic [TB_ADDR-1:0] expLastRd;
    logic [TB_ADDR-1:0] expLastWr;
  } vec_t;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Start one pass and record WINDOW cycles. Optional abort/start/reset
  // injection: abortAt/rstAt name the cycle whose opening edge samples them,
  // restartAt names the cycle during which a second start is driven.
  task automatic applyStimulus(input int n, input logic [TB_ADDR-1:0] src,
                               input logic [TB_ADDR-1:0] dst, input int abortAt,
                               input int restartAt, input int rstAt);
    @(negedge clk);
    cfgNumRows = (TB_ADDR+1)'(n);
    cfgSrc     = src;
    cfgDst     = dst;
    start      = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= WINDOW; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      trBusy[c] = busy;   trDone[c] = done;
      trWe[c]   = weRl;   trFifo[c] = fifoRdEn;
      trRd[c]   = ubRdEn; trWr[c]   = resWrEn;
      trRdAddr[c] = ubRdAddr;
      trWrAddr[c] = resWrAddr;
      if (c + 1 == abortAt) abort = 1'b1;
      if (c == restartAt) begin
        start      = 1'b1;
        cfgNumRows = 11'd7;
        cfgSrc     = 10'h155;
        cfgDst     = 10'h2AA;
      end
      if (c + 1 == rstAt) begin
        rst   = 1'b1;
        abort = 1'b1;
        start = 1'b1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic summarise(input logic [TB_ADDR-1:0] src, input logic [TB_ADDR-1:0] dst);
    logic [TB_ADDR-1:0] expA;
    nRd = 0; nWr = 0; nDone = 0; doneCyc = -1; firstRd = -1; firstWr = -1;
    nOverlap = 0; nBusy = 0; nWe = 0; nFifo = 0;
    weShapeErr = 0; fifoShapeErr = 0; rdAddrErr = 0; wrAddrErr = 0;
    lastRdAddr = '0; lastWrAddr = '0;
    for (int c = 1; c <= WINDOW; c++) begin
      if (trRd[c]) begin
        if (nRd == 0) firstRd = c;
        expA = src + TB_ADDR'(nRd);
        if (trRdAddr[c] != expA) rdAddrErr++;
        lastRdAddr = trRdAddr[c];
        nRd++;
      end
      if (trWr[c]) begin
        if (nWr == 0) firstWr = c;
        expA = dst + TB_ADDR'(nWr);
        if (trWrAddr[c] != expA) wrAddrErr++;
        lastWrAddr = trWrAddr[c];
        nWr++;
      end
      if (trDone[c]) begin
        if (nDone == 0) doneCyc = c;
        nDone++;
      end
      if (trBusy[c]) nBusy++;
      if (trRd[c] && trWr[c]) nOverlap++;
      if (trWe[c]) nWe++;
      if (trFifo[c]) nFifo++;
      if (trWe[c] != (c >= 1 && c <= TB_WLOAD)) weShapeErr++;
      if (trFifo[c] != (c == 1)) fifoShapeErr++;
    end
  endtask

  vec_t vecs[4];
  int   strobesLate, busyLate;

  initial begin
    vecs[0] = '{n: 4,  src: 10'h010, dst: 10'h200, expDone: 21, expBusy: 20, expOverlap: 0,
                expFirstRd: 5, expFirstWr: 17, expLastRd: 10'h013, expLastWr: 10'h203};
    vecs[1] = '{n: 3,  src: 10'h3FF, dst: 10'h3FE, expDone: 20, expBusy: 19, expOverlap: 0,
                expFirstRd: 5, expFirstWr: 17, expLastRd: 10'h001, expLastWr: 10'h000};
    vecs[2] = '{n: 0,  src: 10'h0AB, dst: 10'h0CD, expDone: 17, expBusy: 16, expOverlap: 0,
                expFirstRd: -1, expFirstWr: -1, expLastRd: 10'h000, expLastWr: 10'h000};
    vecs[3] = '{n: 20, src: 10'h100, dst: 10'h080, expDone: 37, expBusy: 36, expOverlap: 8,
                expFirstRd: 5, expFirstWr: 17, expLastRd: 10'h113, expLastWr: 10'h093};

    $display("[TB] default result latency %0d, bench result latency %0d", DEF_RESULT_LAT, TB_RESULT_LAT);
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfgNumRows = '0; cfgSrc = '0; cfgDst = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset strobes", int'({fifoRdEn, weRl, ubRdEn, resWrEn}), 0);
    checkOutput("reset addrs", int'({ubRdAddr, resWrAddr}), 0);
`ifdef TPU_SEQ_PERF_EN
    checkOutput("reset perf", int'(perfCycles), 0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].n, vecs[i].src, vecs[i].dst, -1, -1, -1);
      summarise(vecs[i].src, vecs[i].dst);
      $display("[TB] vector %0d: N=%0d src=%03h dst=%03h", i, vecs[i].n, vecs[i].src, vecs[i].dst);
      checkOutput("read count", nRd, vecs[i].n);
      checkOutput("write count", nWr, vecs[i].n);
      checkOutput("done pulses", nDone, 1);
      checkOutput("done cycle", doneCyc, vecs[i].expDone);
      checkOutput("busy cycles", nBusy, vecs[i].expBusy);
      checkOutput("busy before done", int'(trBusy[vecs[i].expDone - 1]), 1);
      checkOutput("busy at done", int'(trBusy[vecs[i].expDone]), 0);
      checkOutput("rd/wr overlap", nOverlap, vecs[i].expOverlap);
      checkOutput("first read cycle", firstRd, vecs[i].expFirstRd);
      checkOutput("first write cycle", firstWr, vecs[i].expFirstWr);
      checkOutput("read addr errors", rdAddrErr, 0);
      checkOutput("write addr errors", wrAddrErr, 0);
      checkOutput("last read addr", int'(lastRdAddr), int'(vecs[i].expLastRd));
      checkOutput("last write addr", int'(lastWrAddr), int'(vecs[i].expLastWr));
      checkOutput("we_rl count", nWe, TB_WLOAD);
      checkOutput("we_rl shape errors", weShapeErr, 0);
      checkOutput("fifo_rd_en count", nFifo, 1);
      checkOutput("fifo_rd_en shape errors", fifoShapeErr, 0);
`ifdef TPU_SEQ_PERF_EN
      checkOutput("perf cycles", int'(perfCycles), vecs[i].expBusy);
`endif
    end

    $display("[TB] abort sampled at the edge opening cycle 7");
    applyStimulus(4, 10'h010, 10'h200, 7, -1, -1);
    summarise(10'h010, 10'h200);
    strobesLate = 0;
    busyLate    = 0;
    for (int c = 7; c <= WINDOW; c++) begin
      if (trWe[c] || trFifo[c] || trRd[c] || trWr[c] || trDone[c]) strobesLate++;
      if (trBusy[c]) busyLate++;
    end
    checkOutput("abort reads before", nRd, 2);
    checkOutput("abort strobes after", strobesLate, 0);
    checkOutput("abort busy after", busyLate, 0);
    checkOutput("abort done pulses", nDone, 0);
    checkOutput("abort busy at cycle 6", int'(trBusy[6]), 1);
`ifdef TPU_SEQ_PERF_EN
    checkOutput("abort perf hold", int'(perfCycles), 6);
`endif

    $display("[TB] second start during a pass with altered cfg");
    applyStimulus(4, 10'h010, 10'h200, -1, 10, -1);
    summarise(10'h010, 10'h200);
    checkOutput("restart done cycle", doneCyc, 21);
    checkOutput("restart done pulses", nDone, 1);
    checkOutput("restart reads", nRd, 4);
    checkOutput("restart writes", nWr, 4);
    checkOutput("restart addr errors", rdAddrErr + wrAddrErr, 0);
    checkOutput("restart busy cycles", nBusy, 20);

    $display("[TB] reset at the edge opening cycle 20 of an N=20 pass");
    applyStimulus(20, 10'h100, 10'h080, -1, -1, 20);
    checkOutput("pre-reset rd and wr", int'({trRd[19], trWr[19]}), 3);
    checkOutput("post-reset busy/done", int'({trBusy[20], trDone[20]}), 0);
    checkOutput("post-reset strobes", int'({trWe[20], trFifo[20], trRd[20], trWr[20]}), 0);
    checkOutput("post-reset addrs", int'({trRdAddr[20], trWrAddr[20]}), 0);
    busyLate = 0;
    for (int c = 20; c <= WINDOW; c++) begin
      if (trBusy[c] || trDone[c] || trRd[c] || trWr[c]) busyLate++;
    end
    checkOutput("post-reset activity", busyLate, 0);
`ifdef TPU_SEQ_PERF_EN
    checkOutput("post-reset perf", int'(perfCycles), 0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/tpu_matmul_sequencer.md
# tpu_matmul_sequencer

Parametrised run controller for the TPU datapath: one `start` pulse executes a complete matrix-multiply pass. A pass is a weight reload, streaming N activation rows out of the Unified Buffer, and writing N result rows to the results SRAM at a programmable base. It replaces the free-running result counter and fixed-cycle state counter with a start/busy/done handshake, run-length and base-address configuration, address wrap and abort. It sits between the host interface and the UB, Weight FIFO, systolic array and result SRAM.

## Interface
- `MATRIX_SIZE`, 64, systolic array dimension.
- `ADDRESSSIZE`, 10, UB and result SRAM address width.
- `WLOAD_CYCLES`, `MATRIX_SIZE`, cycles `we_rl` is held during weight reload (≥1).
- `RESULT_LAT`, `3*MATRIX_SIZE`, cycles from a row's `ub_rd_en` to its `res_wr_en` (≥1): SRAM read, skew, array and de-skew.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `abort` in 1: cancels the pass in progress.
- `cfg_num_rows` in ADDRESSSIZE+1: N, rows to process (0..2^ADDRESSSIZE).
- `cfg_src_base` in ADDRESSSIZE: first UB read address.
- `cfg_dst_base` in ADDRESSSIZE: first result write address.
- `busy` out 1: high from the cycle after an accepted start until DONE.
- `done` out 1: one-cycle completion pulse.
- `fifo_rd_en` out 1: pops one weight set from the Weight FIFO.
- `we_rl` out 1: weight reload strobe to the systolic array.
- `ub_rd_en` out 1: UB read request.
- `ub_rd_addr` out ADDRESSSIZE: UB read address.
- `res_wr_en` out 1: result SRAM write enable.
- `res_wr_addr` out ADDRESSSIZE: result SRAM write address.
- `perf_cycles` out 32: only present with `TPU_SEQ_PERF_EN`.

## Operation
- States: IDLE → WLOAD → RUN → DONE → IDLE.
- IDLE:
  - On `start`, latch the three `cfg_*` inputs and go to WLOAD.
  - Configuration inputs are ignored at all other times.
- WLOAD:
  - Lasts exactly WLOAD_CYCLES cycles.
  - `we_rl` is high on every WLOAD cycle.
  - `fifo_rd_en` is high on the first WLOAD cycle only.
- RUN, with t counting 0,1,… from the first RUN cycle:
  - `ub_rd_en` is high for t∈[0,N−1], with `ub_rd_addr` = (src_base + t) mod 2^ADDRESSSIZE.
  - `res_wr_en` is high for t∈[RESULT_LAT, RESULT_LAT+N−1], with `res_wr_addr` = (dst_base + t − RESULT_LAT) mod 2^ADDRESSSIZE.
  - Reads and writes overlap when N > RESULT_LAT.
  - Leave RUN after t = RESULT_LAT+N−1.
- N = 0: WLOAD still runs; RUN lasts RESULT_LAT cycles with no reads or writes; then DONE.
- DONE: `done` = 1 for one cycle, `busy` = 0, next state IDLE.
- `start` while not in IDLE: ignored; no queueing.
- `abort` in WLOAD or RUN:
  - Next state is IDLE, and all strobes go low in the same cycle `abort` is sampled.
  - No `done` pulse.
  - Writes already issued stay.
- `abort` has no effect in IDLE or DONE.
- Simultaneous `abort` and `start` in IDLE: `start` wins.
- Address arithmetic is unsigned and wraps silently at 2^ADDRESSSIZE. The row counter is ADDRESSSIZE+1 bits wide, so N = 2^ADDRESSSIZE is legal.

## Timing
- Reset values: state IDLE. `busy`, `done`, `fifo_rd_en`, `we_rl`, `ub_rd_en`, `res_wr_en` are 0. `ub_rd_addr`, `res_wr_addr` are 0. `perf_cycles` is 0.
- All outputs are registered.
- `start` sampled at edge k → first WLOAD cycle is k+1.
- First `ub_rd_en` is at k+1+WLOAD_CYCLES.
- `done` is at k+1+WLOAD_CYCLES+RESULT_LAT+N.
- Earliest next accepted `start` is the cycle after `done`.
- `rst` mid-pass forces the reset values on the next edge and overrides `abort` and `start`.

## Configuration
- `TPU_SEQ_PERF_EN` defined:
  - Adds the `perf_cycles` port.
  - Clears on accepted `start`, increments every cycle while `busy`, holds after `done` or abort.
- Macro undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `tpu_pkg` holds:
  - the state enum (IDLE, WLOAD, RUN, DONE);
  - defaults for MATRIX_SIZE, ADDRESSSIZE and RESULT_LAT, so top level and bench agree.
- One sub-module, `tpu_addr_gen`: a loadable base + offset wrap-around address counter with enable. It is instantiated twice, once for the read side and once for the write side.

## Test plan
- Params MATRIX_SIZE=4, WLOAD_CYCLES=4, RESULT_LAT=12; N=4, src=0x010, dst=0x200; start at cycle 0:
  - `we_rl` high on cycles 1–4; `fifo_rd_en` high on cycle 1 only.
  - Reads 0x010–0x013 on cycles 5–8.
  - Writes 0x200–0x203 on cycles 17–20.
  - `done` on cycle 21.
- Wrap, same params: N=3, src=0x3FF, dst=0x3FE → reads 0x3FF, 0x000, 0x001; writes 0x3FE, 0x3FF, 0x000.
- N=0 → no `ub_rd_en` or `res_wr_en`; `done` on cycle 17; `busy` high cycles 1–16.
- N=20 > RESULT_LAT → `ub_rd_en` and `res_wr_en` both high on cycles 17–24; 20 writes in total; `done` on cycle 37.
- Abort and start handling:
  - `abort` on cycle 7 of the first scenario → no strobes from cycle 7 on, no `done`, IDLE.
  - A `start` on cycle 10 of a normal pass is ignored.
- With `TPU_SEQ_PERF_EN`, first scenario → `perf_cycles` = 20 after `done`.
- Reset mid-RUN → all outputs return to 0 on the next edge.
